// File: rtl/scale_controller_if.sv
// Streaming bus between the video timing generator and the scale controller.
// Master drives button/frame/pixel counters; slave returns scale state and fb address.
interface scale_controller_if #(
   parameter int ADDR_W = 17
);
   logic              btn_in;
   logic              new_frame_in;
   logic [10:0]       hcount_in;
   logic [9:0]        vcount_in;
   logic [1:0]        scale_out;
   logic              pending_out;
   logic [ADDR_W-1:0] addr_out;
   logic              valid_out;

   modport master (
      output btn_in, new_frame_in, hcount_in, vcount_in,
      input  scale_out, pending_out, addr_out, valid_out
   );

   modport slave (
      input  btn_in, new_frame_in, hcount_in, vcount_in,
      output scale_out, pending_out, addr_out, valid_out
   );
endinterface

// File: rtl/scale_controller.sv
// Button-driven scale select (1x/2x/8-3x) committed at frame start; frame-buffer address pipeline.
// Fixed 2-cycle pixel-to-address latency; no backpressure, one result streamed per clock.
module scale_controller #(
   parameter int FB_WIDTH  = 240,
   parameter int FB_HEIGHT = 320,
   parameter int ADDR_W    = 17
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   scale_controller_if.slave bus
);

   localparam logic [10:0] L_H_1X = 11'(FB_WIDTH);
   localparam logic [9:0]  L_V_1X = 10'(FB_HEIGHT);
   localparam logic [10:0] L_H_2X = 11'(2 * FB_WIDTH);
   localparam logic [9:0]  L_V_2X = 10'(2 * FB_HEIGHT);
   localparam logic [10:0] L_H_83 = 11'((8 * FB_WIDTH) / 3);
   localparam logic [9:0]  L_V_83 = 10'((8 * FB_HEIGHT) / 3);

   logic              r_btn_hist;
   logic [1:0]        r_pend;
   logic [1:0]        r_scale;
   logic              r_pending;
   logic [7:0]        r_x;
   logic [8:0]        r_y;
   logic              r_win;
   logic [ADDR_W-1:0] r_addr;
   logic              r_valid;

   logic              w_edge;
   logic [1:0]        w_pend_dec;
   logic [1:0]        w_scale_dec;
   logic [1:0]        w_pend_next;
   logic [1:0]        w_scale_next;
   logic [12:0]       w_h3;
   logic [11:0]       w_v3;
   logic [7:0]        w_x;
   logic [8:0]        w_y;
   logic              w_win;
   logic [ADDR_W-1:0] w_addr;

   // The 11 encoding never occurs, but decode it as 8/3x so the block can't wedge.
   assign w_pend_dec  = (r_pend  == 2'b11) ? 2'b10 : r_pend;
   assign w_scale_dec = (r_scale == 2'b11) ? 2'b10 : r_scale;
   assign w_edge      = bus.btn_in & ~r_btn_hist;

   always_comb begin
      w_pend_next = w_pend_dec;
      if (w_edge) begin
         case (w_pend_dec)
            2'b00:   w_pend_next = 2'b01;
            2'b01:   w_pend_next = 2'b10;
            default: w_pend_next = 2'b00;
         endcase
      end
   end

   // Commit uses the pending value from before this cycle's button update.
   assign w_scale_next = bus.new_frame_in ? w_pend_dec : r_scale;

   assign w_h3 = 13'(bus.hcount_in) * 13'd3;
   assign w_v3 = 12'(bus.vcount_in) * 12'd3;

   always_comb begin
      w_x   = 8'(bus.hcount_in);
      w_y   = 9'(bus.vcount_in);
      w_win = (bus.hcount_in < L_H_1X) && (bus.vcount_in < L_V_1X);
      case (w_scale_dec)
         2'b01: begin
            w_x   = 8'(bus.hcount_in >> 1);
            w_y   = 9'(bus.vcount_in >> 1);
            w_win = (bus.hcount_in < L_H_2X) && (bus.vcount_in < L_V_2X);
         end
         2'b10: begin
            w_x   = 8'(w_h3 >> 3);
            w_y   = 9'(w_v3 >> 3);
            w_win = (bus.hcount_in < L_H_83) && (bus.vcount_in < L_V_83);
         end
         default: ;
      endcase
   end

   assign w_addr = ADDR_W'(r_x) + ADDR_W'(r_y) * ADDR_W'(FB_WIDTH);

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_btn_hist <= 1'b1;
         r_pend     <= 2'b00;
         r_scale    <= 2'b00;
         r_pending  <= 1'b0;
         r_x        <= '0;
         r_y        <= '0;
         r_win      <= 1'b0;
         r_addr     <= '0;
         r_valid    <= 1'b0;
      end else begin
         r_btn_hist <= bus.btn_in;
         r_pend     <= w_pend_next;
         r_scale    <= w_scale_next;
         r_pending  <= (w_pend_next != w_scale_next);
         r_x        <= w_x;
         r_y        <= w_y;
         r_win      <= w_win;
         r_addr     <= r_win ? w_addr : '0;
         r_valid    <= r_win;
      end
   end

   assign bus.scale_out   = r_scale;
   assign bus.pending_out = r_pending;
   assign bus.addr_out    = r_addr;
   assign bus.valid_out   = r_valid;

endmodule

// File: tb/tb_scale_controller.sv
// Directed bench for scale_controller: reset, per-scale addressing, commit timing, wrap, mid-stream reset.
module tb_scale_controller;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   scale_controller_if #(.ADDR_W(17)) bus ();

   scale_controller #(.FB_WIDTH(240), .FB_HEIGHT(320), .ADDR_W(17)) dut (
      .clk_in  (clk),
      .rst_n_in(rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic press();
      bus.btn_in = 1'b1;
      tick(1);
      bus.btn_in = 1'b0;
      tick(1);
   endtask

   task automatic frame();
      bus.new_frame_in = 1'b1;
      tick(1);
      bus.new_frame_in = 1'b0;
   endtask

   task automatic pix(input int h, input int v);
      bus.hcount_in = 11'(h);
      bus.vcount_in = 10'(v);
      tick(2);
   endtask

   task automatic test_reset();
      bus.btn_in = 1'b1;
      bus.new_frame_in = 1'b0;
      bus.hcount_in = 11'd2047;
      bus.vcount_in = 10'd1023;
      rst_n = 1'b0;
      tick(3);
      checks++;
      if (bus.valid_out !== 1'b0 || bus.addr_out !== 17'd0) begin
         failures++;
         $display("FAIL reset_in_reset addr=%0d valid=%0d required addr=0 valid=0", bus.addr_out, bus.valid_out);
      end
      rst_n = 1'b1;
      tick(3);
      checks++;
      if (bus.scale_out !== 2'b00) begin
         failures++;
         $display("FAIL reset_scale got=%0d required=0", bus.scale_out);
      end
      checks++;
      if (bus.pending_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_held_btn_pending got=%0d required=0", bus.pending_out);
      end
      checks++;
      if (bus.addr_out !== 17'd0 || bus.valid_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_addr addr=%0d valid=%0d required addr=0 valid=0", bus.addr_out, bus.valid_out);
      end
      bus.btn_in = 1'b0;
      frame();
      tick(1);
      checks++;
      if (bus.scale_out !== 2'b00 || bus.pending_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_no_press scale=%0d pending=%0d required scale=0 pending=0", bus.scale_out, bus.pending_out);
      end
   endtask

   task automatic test_scale_1x();
      pix(10, 2);
      checks++;
      if (bus.addr_out !== 17'd490 || bus.valid_out !== 1'b1) begin
         failures++;
         $display("FAIL 1x_10_2 addr=%0d valid=%0d required addr=490 valid=1", bus.addr_out, bus.valid_out);
      end
      pix(240, 0);
      checks++;
      if (bus.addr_out !== 17'd0 || bus.valid_out !== 1'b0) begin
         failures++;
         $display("FAIL 1x_h240 addr=%0d valid=%0d required addr=0 valid=0", bus.addr_out, bus.valid_out);
      end
      pix(239, 319);
      checks++;
      if (bus.addr_out !== 17'd76799 || bus.valid_out !== 1'b1) begin
         failures++;
         $display("FAIL 1x_corner addr=%0d valid=%0d required addr=76799 valid=1", bus.addr_out, bus.valid_out);
      end
      pix(0, 320);
      checks++;
      if (bus.addr_out !== 17'd0 || bus.valid_out !== 1'b0) begin
         failures++;
         $display("FAIL 1x_v320 addr=%0d valid=%0d required addr=0 valid=0", bus.addr_out, bus.valid_out);
      end
   endtask

   task automatic test_press_commit();
      press();
      checks++;
      if (bus.pending_out !== 1'b1 || bus.scale_out !== 2'b00) begin
         failures++;
         $display("FAIL press_pending scale=%0d pending=%0d required scale=0 pending=1", bus.scale_out, bus.pending_out);
      end
      pix(300, 0);
      checks++;
      if (bus.valid_out !== 1'b0) begin
         failures++;
         $display("FAIL press_no_early_commit valid=%0d required=0", bus.valid_out);
      end
      frame();
      checks++;
      if (bus.scale_out !== 2'b01 || bus.pending_out !== 1'b0) begin
         failures++;
         $display("FAIL press_commit scale=%0d pending=%0d required scale=1 pending=0", bus.scale_out, bus.pending_out);
      end
      pix(479, 639);
      checks++;
      if (bus.addr_out !== 17'd76799 || bus.valid_out !== 1'b1) begin
         failures++;
         $display("FAIL 2x_corner addr=%0d valid=%0d required addr=76799 valid=1", bus.addr_out, bus.valid_out);
      end
      pix(480, 639);
      checks++;
      if (bus.addr_out !== 17'd0 || bus.valid_out !== 1'b0) begin
         failures++;
         $display("FAIL 2x_h480 addr=%0d valid=%0d required addr=0 valid=0", bus.addr_out, bus.valid_out);
      end
      pix(300, 0);
      checks++;
      if (bus.addr_out !== 17'd150 || bus.valid_out !== 1'b1) begin
         failures++;
         $display("FAIL 2x_300_0 addr=%0d valid=%0d required addr=150 valid=1", bus.addr_out, bus.valid_out);
      end
   endtask

   task automatic test_two_presses();
      do_reset();
      press();
      press();
      checks++;
      if (bus.pending_out !== 1'b1 || bus.scale_out !== 2'b00) begin
         failures++;
         $display("FAIL two_press_pending scale=%0d pending=%0d required scale=0 pending=1", bus.scale_out, bus.pending_out);
      end
      frame();
      checks++;
      if (bus.scale_out !== 2'b10 || bus.pending_out !== 1'b0) begin
         failures++;
         $display("FAIL two_press_commit scale=%0d pending=%0d required scale=2 pending=0", bus.scale_out, bus.pending_out);
      end
      pix(639, 852);
      checks++;
      if (bus.addr_out !== 17'd76799 || bus.valid_out !== 1'b1) begin
         failures++;
         $display("FAIL 83x_corner addr=%0d valid=%0d required addr=76799 valid=1", bus.addr_out, bus.valid_out);
      end
      pix(8, 8);
      checks++;
      if (bus.addr_out !== 17'd723 || bus.valid_out !== 1'b1) begin
         failures++;
         $display("FAIL 83x_8_8 addr=%0d valid=%0d required addr=723 valid=1", bus.addr_out, bus.valid_out);
      end
      pix(640, 0);
      checks++;
      if (bus.addr_out !== 17'd0 || bus.valid_out !== 1'b0) begin
         failures++;
         $display("FAIL 83x_h640 addr=%0d valid=%0d required addr=0 valid=0", bus.addr_out, bus.valid_out);
      end
      pix(0, 853);
      checks++;
      if (bus.addr_out !== 17'd0 || bus.valid_out !== 1'b0) begin
         failures++;
         $display("FAIL 83x_v853 addr=%0d valid=%0d required addr=0 valid=0", bus.addr_out, bus.valid_out);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      press();
      bus.btn_in = 1'b1;
      bus.new_frame_in = 1'b1;
      tick(1);
      bus.btn_in = 1'b0;
      bus.new_frame_in = 1'b0;
      checks++;
      if (bus.scale_out !== 2'b01 || bus.pending_out !== 1'b1) begin
         failures++;
         $display("FAIL same_cycle_commit scale=%0d pending=%0d required scale=1 pending=1", bus.scale_out, bus.pending_out);
      end
      tick(1);
      frame();
      checks++;
      if (bus.scale_out !== 2'b10 || bus.pending_out !== 1'b0) begin
         failures++;
         $display("FAIL same_cycle_next_frame scale=%0d pending=%0d required scale=2 pending=0", bus.scale_out, bus.pending_out);
      end
   endtask

   task automatic test_wrap_and_reset();
      press();
      checks++;
      if (bus.pending_out !== 1'b1 || bus.scale_out !== 2'b10) begin
         failures++;
         $display("FAIL wrap_pending scale=%0d pending=%0d required scale=2 pending=1", bus.scale_out, bus.pending_out);
      end
      frame();
      checks++;
      if (bus.scale_out !== 2'b00 || bus.pending_out !== 1'b0) begin
         failures++;
         $display("FAIL wrap_commit scale=%0d pending=%0d required scale=0 pending=0", bus.scale_out, bus.pending_out);
      end
      pix(10, 2);
      checks++;
      if (bus.addr_out !== 17'd490 || bus.valid_out !== 1'b1) begin
         failures++;
         $display("FAIL wrap_1x addr=%0d valid=%0d required addr=490 valid=1", bus.addr_out, bus.valid_out);
      end
      press();
      frame();
      pix(20, 2);
      checks++;
      if (bus.addr_out !== 17'd250 || bus.valid_out !== 1'b1 || bus.scale_out !== 2'b01) begin
         failures++;
         $display("FAIL prereset_2x addr=%0d valid=%0d scale=%0d required addr=250 valid=1 scale=1", bus.addr_out, bus.valid_out, bus.scale_out);
      end
      rst_n = 1'b0;
      tick(1);
      checks++;
      if (bus.addr_out !== 17'd0 || bus.valid_out !== 1'b0 || bus.scale_out !== 2'b00) begin
         failures++;
         $display("FAIL midstream_reset addr=%0d valid=%0d scale=%0d required addr=0 valid=0 scale=0", bus.addr_out, bus.valid_out, bus.scale_out);
      end
      rst_n = 1'b1;
      pix(20, 2);
      checks++;
      if (bus.addr_out !== 17'd500 || bus.valid_out !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_1x addr=%0d valid=%0d required addr=500 valid=1", bus.addr_out, bus.valid_out);
      end
   endtask

   initial begin
      bus.btn_in = 1'b0;
      bus.new_frame_in = 1'b0;
      bus.hcount_in = '0;
      bus.vcount_in = '0;
      test_reset();
      test_scale_1x();
      test_press_commit();
      test_two_presses();
      test_same_cycle();
      test_wrap_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
